// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: Execute-stage forwarding selects, load-use stalls,
// taken-branch flushes, data-memory freeze with timeout, and post-reset front-end hold.
module hazard_controller #(
    parameter int unsigned STARTUP_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT    = 64,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           IDRs1,
    input  logic [2:0]           IDRs2,
    input  logic [2:0]           IDRd,
    input  logic                 IDUsesRs1,
    input  logic                 IDUsesRs2,
    input  logic                 IDIsStore,
    input  logic [2:0]           EXRs1,
    input  logic [2:0]           EXRs2,
    input  logic [2:0]           EXRd,
    input  logic                 EXMemRead,
    input  logic                 EXMemWrite,
    input  logic                 EXBranchTaken,
    input  logic [2:0]           MEMRd,
    input  logic                 MEMRegWrite,
    input  logic [2:0]           WBRd,
    input  logic                 WBRegWrite,
    input  logic                 memBusy,
    output logic [1:0]           muxFwd1select,
    output logic [1:0]           muxFwd2select,
    output logic                 muxFwd3select,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 IFIDFlush,
    output logic                 IDEXFlush,
    output logic                 pipeHold,
    output logic                 memTimeout,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] flushCount
);

    // Init counter only needs to reach STARTUP_CYCLES-1; wait counter must hold MEM_TIMEOUT.
    localparam int unsigned INIT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [INIT_W-1:0]     r_init_cnt;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic                  r_mem_timeout;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;
    logic                  w_stall_inc;
    logic                  w_flush_inc;
    logic                  w_load_use;
    logic                  w_mem_hit1;
    logic                  w_mem_hit2;
    logic                  w_wb_hit1;
    logic                  w_wb_hit2;

    assign memTimeout = r_mem_timeout;
    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;

    // Source-register matches against later-stage destinations; r0 never forwarded.
    always_comb begin
        w_mem_hit1 = MEMRegWrite && (MEMRd != 3'd0) && (MEMRd == EXRs1);
        w_mem_hit2 = MEMRegWrite && (MEMRd != 3'd0) && (MEMRd == EXRs2);
        w_wb_hit1  = WBRegWrite  && (WBRd  != 3'd0) && (WBRd  == EXRs1);
        w_wb_hit2  = WBRegWrite  && (WBRd  != 3'd0) && (WBRd  == EXRs2);
        w_load_use = EXMemRead && (EXRd != 3'd0) &&
                     ((IDUsesRs1 && (EXRd == IDRs1)) ||
                      (IDUsesRs2 && (EXRd == IDRs2)) ||
                      (IDIsStore && (EXRd == IDRd)));
    end

    // Forwarding selects; MEM has priority over WB, all forced to 0 while in INIT.
    always_comb begin
        muxFwd1select = 2'd0;
        muxFwd2select = 2'd0;
        muxFwd3select = 1'b0;
        if (r_state != ST_INIT) begin
            if (w_mem_hit1)     muxFwd1select = 2'd1;
            else if (w_wb_hit1) muxFwd1select = 2'd2;
            if (w_mem_hit2)     muxFwd2select = 2'd1;
            else if (w_wb_hit2) muxFwd2select = 2'd2;
            muxFwd3select = EXMemWrite && MEMRegWrite && (MEMRd != 3'd0) && (MEMRd == EXRd);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state and pipeline control; memBusy freezes, then branch > load-use > normal.
    always_comb begin
        w_state_nxt = r_state;
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        pipeHold    = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            ST_INIT: begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
                if (r_init_cnt == INIT_W'(STARTUP_CYCLES - 1)) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_MEMWAIT: begin
                if (memBusy) begin
                    pipeHold    = 1'b1;
                    w_stall_inc = 1'b1;
                    w_state_nxt = ST_MEMWAIT;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (EXBranchTaken) begin
                        PCWrite     = 1'b1;
                        IFIDWrite   = 1'b1;
                        IFIDFlush   = 1'b1;
                        IDEXFlush   = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        IDEXFlush   = 1'b1;
                        w_stall_inc = 1'b1;
                    end else begin
                        PCWrite   = 1'b1;
                        IFIDWrite = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                IFIDFlush   = 1'b1;
                IDEXFlush   = 1'b1;
            end
        endcase
    end

    // Startup hold counter, counts edges spent in INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_init_cnt <= '0;
        else if ((r_state == ST_INIT) && (w_state_nxt == ST_INIT))
            r_init_cnt <= r_init_cnt + INIT_W'(1);
        else
            r_init_cnt <= '0;
    end

    // Consecutive busy-cycle count; the first busy cycle (still in RUN) counts as 1.
    always_comb begin
        w_wait_nxt = '0;
        if (w_state_nxt == ST_MEMWAIT) begin
            if (r_state != ST_MEMWAIT)
                w_wait_nxt = WAIT_W'(1);
            else if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT))
                w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            else
                w_wait_nxt = r_wait_cnt;
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt >= WAIT_W'(MEM_TIMEOUT)) r_mem_timeout <= 1'b1;
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: startup hold, forwarding, load-use,
// branch priority, memory freeze with timeout, and reset during a freeze.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  IDRs1, IDRs2, IDRd, EXRs1, EXRs2, EXRd, MEMRd, WBRd;
    logic        IDUsesRs1, IDUsesRs2, IDIsStore, EXMemRead, EXMemWrite, EXBranchTaken;
    logic        MEMRegWrite, WBRegWrite, memBusy;
    logic [1:0]  muxFwd1select, muxFwd2select;
    logic        muxFwd3select, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold, memTimeout;
    logic [15:0] stallCount, flushCount;

    int n_vec = 0;
    int n_err = 0;

    // Control bundle {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold}
    localparam logic [4:0] C_RST    = 5'b00110;
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_BRANCH = 5'b11110;
    localparam logic [4:0] C_BUSY   = 5'b00001;

    hazard_controller #(.STARTUP_CYCLES(2), .MEM_TIMEOUT(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .IDRs1(IDRs1), .IDRs2(IDRs2), .IDRd(IDRd),
        .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2), .IDIsStore(IDIsStore),
        .EXRs1(EXRs1), .EXRs2(EXRs2), .EXRd(EXRd),
        .EXMemRead(EXMemRead), .EXMemWrite(EXMemWrite), .EXBranchTaken(EXBranchTaken),
        .MEMRd(MEMRd), .MEMRegWrite(MEMRegWrite), .WBRd(WBRd), .WBRegWrite(WBRegWrite),
        .memBusy(memBusy),
        .muxFwd1select(muxFwd1select), .muxFwd2select(muxFwd2select), .muxFwd3select(muxFwd3select),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .pipeHold(pipeHold), .memTimeout(memTimeout),
        .stallCount(stallCount), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ctl();
        return 32'({PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeHold});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {IDRs1, IDRs2, IDRd, EXRs1, EXRs2, EXRd, MEMRd, WBRd} = '0;
        {IDUsesRs1, IDUsesRs2, IDIsStore, EXMemRead, EXMemWrite, EXBranchTaken} = '0;
        {MEMRegWrite, WBRegWrite, memBusy} = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, ctl(), 32'(C_RST));
        chk({tag, "_fwd"}, 32'({muxFwd1select, muxFwd2select, muxFwd3select}), 32'd0);
        chk({tag, "_tmo"}, 32'(memTimeout), 32'd0);
        chk({tag, "_stall"}, 32'(stallCount), 32'd0);
        chk({tag, "_flush"}, 32'(flushCount), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        clr();
        #2;
        chk_reset_vals("rst");

        // Release reset; forwarding candidates present but suppressed in INIT
        @(negedge clk);
        reset = 1'b1;
        EXRs1 = 3'd3; MEMRd = 3'd3; MEMRegWrite = 1'b1; WBRd = 3'd3; WBRegWrite = 1'b1;
        #1;
        chk("init0_ctl", ctl(), 32'(C_RST));
        chk("init0_sel1", 32'(muxFwd1select), 32'd0);
        @(negedge clk); #1;
        chk("init1_ctl", ctl(), 32'(C_RST));
        @(negedge clk); #1;
        chk("run_ctl", ctl(), 32'(C_RUN));
        chk("fwd_mem_wins", 32'(muxFwd1select), 32'd1);

        @(negedge clk); MEMRd = 3'd0; #1;
        chk("fwd_wb", 32'(muxFwd1select), 32'd2);
        @(negedge clk); EXRs1 = 3'd0; #1;
        chk("fwd_r0", 32'(muxFwd1select), 32'd0);
        @(negedge clk); clr(); EXRs2 = 3'd4; WBRd = 3'd4; WBRegWrite = 1'b1; MEMRd = 3'd4; #1;
        chk("fwd2_wb", 32'(muxFwd2select), 32'd2);
        @(negedge clk); MEMRegWrite = 1'b1; #1;
        chk("fwd2_mem", 32'(muxFwd2select), 32'd1);
        @(negedge clk); clr(); EXMemWrite = 1'b1; EXRd = 3'd6; MEMRd = 3'd6; MEMRegWrite = 1'b1; #1;
        chk("fwd3_hit", 32'(muxFwd3select), 32'd1);
        @(negedge clk); MEMRegWrite = 1'b0; #1;
        chk("fwd3_nowr", 32'(muxFwd3select), 32'd0);

        // Load-use via Rs2
        @(negedge clk); clr(); EXMemRead = 1'b1; EXRd = 3'd5; IDRs2 = 3'd5; IDUsesRs2 = 1'b1; #1;
        chk("lu_rs2_ctl", ctl(), 32'(C_STALL));
        chk("lu_rs2_cnt0", 32'(stallCount), 32'd0);
        @(negedge clk); clr(); #1;
        chk("lu_after_ctl", ctl(), 32'(C_RUN));
        chk("lu_cnt1", 32'(stallCount), 32'd1);
        // Load to r0 is not a hazard
        @(negedge clk); EXMemRead = 1'b1; EXRd = 3'd0; IDRs1 = 3'd0; IDUsesRs1 = 1'b1; #1;
        chk("lu_r0_ctl", ctl(), 32'(C_RUN));
        // Store data dependence
        @(negedge clk); clr(); EXMemRead = 1'b1; EXRd = 3'd2; IDRd = 3'd2; IDIsStore = 1'b1; #1;
        chk("lu_store_ctl", ctl(), 32'(C_STALL));
        @(negedge clk); #1;
        chk("lu_cnt2", 32'(stallCount), 32'd2);

        // Branch outranks load-use
        EXBranchTaken = 1'b1; #1;
        chk("br_lu_ctl", ctl(), 32'(C_BRANCH));
        @(negedge clk); clr(); #1;
        chk("br_flush1", 32'(flushCount), 32'd1);
        chk("br_stall_same", 32'(stallCount), 32'd2);

        // 70 busy cycles with a pending branch that must be ignored while frozen
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk); memBusy = 1'b1; EXBranchTaken = 1'b1; #1;
            chk($sformatf("busy%0d_ctl", k), ctl(), 32'(C_BUSY));
            chk($sformatf("busy%0d_tmo", k), 32'(memTimeout), 32'(k >= 65));
        end
        @(negedge clk); memBusy = 1'b0; #1;
        chk("busy_stall70", 32'(stallCount), 32'd72);
        chk("busy_flush_same", 32'(flushCount), 32'd1);
        chk("release_br_ctl", ctl(), 32'(C_BRANCH));
        @(negedge clk); clr(); #1;
        chk("release_flush2", 32'(flushCount), 32'd2);
        chk("tmo_sticky", 32'(memTimeout), 32'd1);
        chk("release_run", ctl(), 32'(C_RUN));

        // Reset asserted mid-freeze
        @(negedge clk); memBusy = 1'b1; #1;
        chk("rst2_busy", ctl(), 32'(C_BUSY));
        @(negedge clk); #1;
        reset = 1'b0; #1;
        chk_reset_vals("rst2");
        @(negedge clk); reset = 1'b1; memBusy = 1'b0; #1;
        chk("rst2_init0", ctl(), 32'(C_RST));
        @(negedge clk); #1;
        chk("rst2_init1", ctl(), 32'(C_RST));
        @(negedge clk); #1;
        chk("rst2_run", ctl(), 32'(C_RUN));
        chk("rst2_tmo", 32'(memTimeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
